csr_bus_arbiter: RTL and testbench
==================================

Name: csr_bus_arbiter

Overview:
- Shares one simple CSR bus (en/we/addr/wdata, registered rdata with 1-cycle latency) among N_REQ requesters.
- Requesters connect through valid/ready command channels. Per-requester response pulses return write acks and read data.
- Sits between software/DPI-driven bus masters and CSR bank slaves at fixed base addresses (e.g. bank at 0xF00).
- One transaction in flight at a time. Round-robin fairness.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ADDR_W, 12, CSR bus address width.
- DATA_W, 32, CSR bus data width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  N_REQ  command valid per requester.
- req_ready  output  N_REQ  command accepted (one-hot or zero).
- req_we  input  N_REQ  1 = write, 0 = read.
- req_addr  input  N_REQ*ADDR_W  packed command addresses.
- req_wdata  input  N_REQ*DATA_W  packed write data.
- rsp_valid  output  N_REQ  one-cycle response pulse per requester.
- rsp_rdata  output  DATA_W  read data, valid with rsp_valid (shared).
- bus_en  output  1  CSR bus enable.
- bus_we  output  1  CSR bus write enable.
- bus_addr  output  ADDR_W  CSR bus address.
- bus_wdata  output  DATA_W  CSR bus write data.
- bus_rdata  input  DATA_W  slave read data, valid the cycle after a read strobe.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, rr pointer=0.
  - All registered outputs 0: bus_en, bus_we, bus_addr, bus_wdata, rsp_valid, rsp_rdata, captured grant id.
  - req_ready forced 0 while rst=1.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, req_ready[g]=1 combinationally for winner g. Otherwise req_ready=0.
  - At the edge: latch g, we, addr, wdata. Load bus_* registers with en=1. Go to ISSUE.
  - No request: stay in IDLE with bus_en=0.
- ISSUE: bus_en=1 for exactly one cycle with the latched we/addr/wdata.
  - Write: next state RESP.
  - Read: next state WAIT.
  - bus_en returns to 0 on leaving ISSUE.
  - bus_we, bus_addr, bus_wdata hold their last values (no requirement to clear).
- WAIT (read only): bus_rdata is valid this cycle. Capture it into rsp_rdata at the edge, then go to RESP.
- RESP: rsp_valid[g]=1 for one cycle. There is no response backpressure. Next state IDLE.
  - rsp_rdata holds until the next read capture.
  - On a write response rsp_rdata is unchanged.
- Latency from the accept edge to the rsp_valid cycle:
  - write: 2 cycles.
  - read: 3 cycles.
- Throughput:
  - write: 3 cycles per transaction.
  - read: 4 cycles per transaction.
  - The next grant is possible in the cycle after RESP.
- Round-robin:
  - Search starts at the pointer, ascending with wrap (N_REQ-1 -> 0).
  - On grant, pointer = g+1 mod N_REQ. The pointer does not change without a grant.
- Requester rules:
  - Once req_valid rises, it and the command fields stay stable until req_ready.
  - A requester may reissue in the cycle after its rsp_valid.
  - req_valid may be high during that requester's own RESP; it is not granted until IDLE.
- Simultaneous events:
  - All valid: grant goes to the first at/after the pointer.
  - A single requester held continuously is served every transaction (no idle gaps beyond the FSM).
- Address handling:
  - Addresses pass through unmodified. No decode, no alignment check.
  - An unmapped read returns whatever the slave drives.
- Reset mid-transaction: the transaction is abandoned and no rsp_valid is issued. Requesters must reissue.

Decomposition:
- Package csr_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e.
  - Default width constants CSR_ADDR_W=12 and CSR_DATA_W=32.
  - Function clog2-safe id width.
- Sub-module rr_arbiter (N parameter; inputs: req vector, pointer; output: one-hot grant plus index; combinational).
  - Pointer register lives in csr_bus_arbiter.

Test Plan:
- Single write: req0 writes 0xF04 <- 0xDEADBEEF.
  - Expect: bus_en=1 one cycle with we=1, addr=0xF04, wdata=0xDEADBEEF.
  - Expect: rsp_valid[0] 2 cycles after the accept edge.
  - Expect: rsp_valid[1] stays 0.
- Read-back: req1 reads 0xF04 after the write.
  - Expect: bus_en with we=0.
  - Expect: rsp_valid[1] 3 cycles after accept, with rsp_rdata=0xDEADBEEF.
- Contention: req0 and req1 both continuously valid, each reading 0xF00/0xF08 (preloaded 0x11/0x22).
  - Expect grants alternating 0,1,0,1 starting from pointer 0.
  - Expect a 4-cycle spacing between rsp_valid pulses with correct data per requester.
- Back-to-back writes from req0 only: 0xF00..0xF1C <- i.
  - Expect a grant every 3 cycles and 8 acks.
  - Reading all 8 back returns 0..7.
- Reset mid-read: assert rst during WAIT.
  - Expect bus_en=0, rsp_valid=0, req_ready=0 immediately.
  - After release: state IDLE, pointer 0, and no stale response pulse.
- Idle and wrap: with N_REQ=3, requests in the order 2 then 0 then 1.
  - Expect the pointer to wrap 2->0 and grants in the order issued, with no spurious bus_en while idle.

Source files
------------

// File: rtl/csr_arb_pkg.sv
// Shared types and width helpers for the CSR bus arbiter.
package csr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

    localparam int CSR_ADDR_W = 12;
    localparam int CSR_DATA_W = 32;

    // Index width that stays at least one bit wide for tiny requester counts.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
module rr_arbiter
    import csr_arb_pkg::*;
#(
    parameter  int N   = 2,
    localparam int IDW = id_width(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   grant_o,
    output logic [IDW-1:0] idx_o,
    output logic           any_o
);

    logic [IDW-1:0] cand;

    // NOTE: every output and temporary gets a value before the search so no latch is inferred.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = ptr_i;
        for (int i = 0; i < N; i++) begin
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
            cand = (cand == IDW'(N - 1)) ? '0 : cand + 1'b1;
        end
    end

endmodule

// File: rtl/csr_bus_arbiter.sv
// Shares one registered-read CSR bus among N_REQ valid/ready requesters, one
// transaction in flight, round-robin between requesters.
module csr_bus_arbiter
    import csr_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = CSR_ADDR_W,
    parameter int DATA_W = CSR_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      bus_en,
    output logic                      bus_we,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic [DATA_W-1:0]         bus_wdata,
    input  logic [DATA_W-1:0]         bus_rdata
);

    localparam int IDW = id_width(N_REQ);

    arb_state_e         state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     gid_q, gid_d;
    logic               bus_en_q, bus_en_d;
    logic               bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]  bus_wdata_q, bus_wdata_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;

    logic [N_REQ-1:0]   gnt_oh;
    logic [N_REQ-1:0]   ready_c;
    logic [IDW-1:0]     gnt_idx;
    logic               gnt_any;
    logic [ADDR_W-1:0]  addr_arr  [N_REQ];
    logic [DATA_W-1:0]  wdata_arr [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
        end
    end

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (gnt_oh),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gid_d       = gid_q;
        bus_en_d    = 1'b0;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        ready_c     = '0;
        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    ready_c     = gnt_oh;
                    gid_d       = gnt_idx;
                    ptr_d       = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    bus_en_d    = 1'b1;
                    bus_we_d    = req_we[gnt_idx];
                    bus_addr_d  = addr_arr[gnt_idx];
                    bus_wdata_d = wdata_arr[gnt_idx];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // Writes skip WAIT: the ack is raised straight after the strobe.
                if (bus_we_q) begin
                    rsp_valid_d = N_REQ'(1) << gid_q;
                    state_d     = RESP;
                end else begin
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                rsp_rdata_d = bus_rdata;
                rsp_valid_d = N_REQ'(1) << gid_q;
                state_d     = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = ready_c & {N_REQ{~rst}};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gid_q       <= '0;
            bus_en_q    <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gid_q       <= gid_d;
            bus_en_q    <= bus_en_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus_en    = bus_en_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_csr_bus_arbiter.sv
// Directed bench for csr_bus_arbiter with three requesters and a registered-read CSR bank at 0xF00.
module tb_csr_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = 12;
    localparam int DW = 32;

    typedef struct {
        logic [N-1:0]  vmask;
        int            r;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, bus_wdata, bus_rdata;
    logic            bus_en, bus_we;
    logic [AW-1:0]   bus_addr;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ack0_cnt = 0;
    logic [DW-1:0] last_rdata;
    logic [DW-1:0] mem [16];
    vec_t tbl [12];

    csr_bus_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .bus_en    (bus_en),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (rsp_valid[0]) ack0_cnt <= ack0_cnt + 1;

    // CSR bank at 0xF00..0xF3C; anything else reads back a tagged address pattern.
    always @(posedge clk) begin
        if (bus_en) begin
            if (bus_we) begin
                if (bus_addr[11:6] == 6'h3C) mem[bus_addr[5:2]] <= bus_wdata;
            end else begin
                bus_rdata <= (bus_addr[11:6] == 6'h3C) ? mem[bus_addr[5:2]] : {20'hBAD00, bus_addr};
            end
        end
    end

    function automatic logic [N-1:0] oh(input int r);
        logic [N-1:0] one;
        one = 1;
        return one << r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int r, output bit ok);
        int k;
        ok = 1'b0;
        k  = 0;
        while (!ok && k < 20) begin
            #1;
            if (req_ready[r]) ok = 1'b1;
            else @(negedge clk);
            k++;
        end
        if (!ok) check("ready_timeout", 64'(req_ready[r]), 64'd1);
    endtask

    task automatic set_cmd(input int k, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        req_we[k]              = we;
        req_addr[k*AW +: AW]   = addr;
        req_wdata[k*DW +: DW]  = wdata;
    endtask

    task automatic do_txn(input vec_t v);
        bit ok;
        @(negedge clk);
        for (int k = 0; k < N; k++) set_cmd(k, v.we, v.addr, v.wdata);
        req_valid = v.vmask;
        wait_ready(v.r, ok);
        if (ok) begin
            check("grant", 64'(req_ready), 64'(oh(v.r)));
            @(negedge clk);
            req_valid[v.r] = 1'b0;
            check("bus_strobe", {bus_en, bus_we, bus_addr, bus_wdata}, {1'b1, v.we, v.addr, v.wdata});
            check("rsp_early", 64'(rsp_valid), 64'd0);
            @(negedge clk);
            check("bus_en_drop", 64'(bus_en), 64'd0);
            if (v.we) begin
                check("wr_ack", 64'(rsp_valid), 64'(oh(v.r)));
                check("wr_rdata_hold", 64'(rsp_rdata), 64'(last_rdata));
            end else begin
                check("rd_rsp_early", 64'(rsp_valid), 64'd0);
                @(negedge clk);
                check("rd_ack", 64'(rsp_valid), 64'(oh(v.r)));
                check("rd_data", 64'(rsp_rdata), 64'(v.exp_rdata));
                last_rdata = v.exp_rdata;
            end
        end else begin
            req_valid = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '1;
        #1;
        check("reset_outputs", {bus_en, bus_we, bus_addr, bus_wdata, rsp_valid, req_ready}, 64'd0);
        check("reset_rdata", 64'(rsp_rdata), 64'd0);
        @(negedge clk);
        rst        = 1'b0;
        req_valid  = '0;
        last_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   npulse, last_c, first_c;
        int   rc [8];
        int   base;
        bit   ok;
        vec_t v;

        tbl[0]  = '{vmask: 3'b001, r: 0, we: 1'b1, addr: 12'hF04, wdata: 32'hDEADBEEF, exp_rdata: 32'h0};
        tbl[1]  = '{vmask: 3'b010, r: 1, we: 1'b0, addr: 12'hF04, wdata: 32'h0,        exp_rdata: 32'hDEADBEEF};
        tbl[2]  = '{vmask: 3'b001, r: 0, we: 1'b1, addr: 12'hF00, wdata: 32'h11,       exp_rdata: 32'h0};
        tbl[3]  = '{vmask: 3'b010, r: 1, we: 1'b1, addr: 12'hF08, wdata: 32'h22,       exp_rdata: 32'h0};
        tbl[4]  = '{vmask: 3'b100, r: 2, we: 1'b0, addr: 12'h123, wdata: 32'h0,        exp_rdata: 32'hBAD00123};
        tbl[5]  = '{vmask: 3'b100, r: 2, we: 1'b1, addr: 12'hF0C, wdata: 32'hA5A55A5A, exp_rdata: 32'h0};
        tbl[6]  = '{vmask: 3'b110, r: 1, we: 1'b0, addr: 12'hF08, wdata: 32'h0,        exp_rdata: 32'h22};
        tbl[7]  = '{vmask: 3'b100, r: 2, we: 1'b0, addr: 12'hF0C, wdata: 32'h0,        exp_rdata: 32'hA5A55A5A};
        tbl[8]  = '{vmask: 3'b110, r: 1, we: 1'b0, addr: 12'hF1C, wdata: 32'h0,        exp_rdata: 32'h7};
        tbl[9]  = '{vmask: 3'b100, r: 2, we: 1'b0, addr: 12'hF10, wdata: 32'h0,        exp_rdata: 32'h4};
        tbl[10] = '{vmask: 3'b011, r: 0, we: 1'b0, addr: 12'hF14, wdata: 32'h0,        exp_rdata: 32'h5};
        tbl[11] = '{vmask: 3'b010, r: 1, we: 1'b1, addr: 12'hF20, wdata: 32'h1234,     exp_rdata: 32'h0};

        rst        = 1'b1;
        req_valid  = '1;
        req_we     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        last_rdata = '0;
        #2;
        check("por_outputs", {bus_en, bus_we, bus_addr, bus_wdata, rsp_valid, req_ready}, 64'd0);
        check("por_rdata", 64'(rsp_rdata), 64'd0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;

        for (int i = 0; i < 8; i++) do_txn(tbl[i]);

        // Contention: both requesters held valid from pointer 0, reads alternate 0,1,0,1.
        do_reset();
        @(negedge clk);
        set_cmd(0, 1'b0, 12'hF00, 32'h0);
        set_cmd(1, 1'b0, 12'hF08, 32'h0);
        req_valid = 3'b011;
        npulse  = 0;
        last_c  = 0;
        first_c = -1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                if (npulse == 0) first_c = c;
                if (npulse < 4) begin
                    check("cont_who", 64'(rsp_valid), 64'(oh(npulse % 2)));
                    check("cont_data", 64'(rsp_rdata), (npulse % 2 == 0) ? 64'h11 : 64'h22);
                    if (npulse > 0) check("cont_spacing", 64'(c - last_c), 64'd4);
                end
                last_c = c;
                npulse++;
            end
            if (c == 15) req_valid = '0;
        end
        check("cont_first", 64'(first_c), 64'd2);
        check("cont_count", 64'(npulse), 64'd4);
        last_rdata = 32'h22;

        // Back-to-back writes from requester 0 only.
        @(negedge clk);
        base = ack0_cnt;
        for (int i = 0; i < 8; i++) begin
            set_cmd(0, 1'b1, 12'(12'hF00 + 4 * i), 32'(i));
            req_valid[0] = 1'b1;
            wait_ready(0, ok);
            rc[i] = cyc;
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b_acks", 64'(ack0_cnt - base), 64'd8);
        for (int i = 1; i < 8; i++) check("b2b_spacing", 64'(rc[i] - rc[i-1]), 64'd3);
        for (int i = 0; i < 8; i++) begin
            v = '{vmask: 3'b001, r: 0, we: 1'b0, addr: 12'(12'hF00 + 4 * i), wdata: 32'h0, exp_rdata: 32'(i)};
            do_txn(v);
        end

        // Reset asserted while the read sits in WAIT.
        @(negedge clk);
        set_cmd(1, 1'b0, 12'hF04, 32'h0);
        req_valid = 3'b010;
        wait_ready(1, ok);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 3'b001;
        #1;
        check("midrst_bus_en", 64'(bus_en), 64'd0);
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_ready", 64'(req_ready), 64'd0);
        check("midrst_rdata", 64'(rsp_rdata), 64'd0);
        @(negedge clk);
        rst        = 1'b0;
        req_valid  = '0;
        last_rdata = '0;
        repeat (5) begin
            @(negedge clk);
            check("idle_quiet", {bus_en, rsp_valid, req_ready}, 64'd0);
        end

        // Pointer restarts at 0, then wraps 2 -> 0.
        for (int i = 8; i < 12; i++) do_txn(tbl[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
